amdc_amds_s00_axi_regs: RTL
===========================

AMDC_AMDS_S00_AXI_REGS -- requirements
Module: amdc_amds_s00_axi_regs

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 4, AXI4-Lite byte address width; decodes 4 word registers.
REQ-003 s00_axi_aclk  in  1  sole clock; all state updates on its rising edge.
REQ-004 s00_axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-005 s00_axi_awaddr  in  4  write address; s00_axi_awprot  in  3  accepted and ignored.
REQ-006 s00_axi_awvalid  in  1 / s00_axi_awready  out  1  write-address handshake.
REQ-007 s00_axi_wdata  in  32  write data; s00_axi_wstrb  in  4  byte enables.
REQ-008 s00_axi_wvalid  in  1 / s00_axi_wready  out  1  write-data handshake.
REQ-009 s00_axi_bresp  out  2  write response; s00_axi_bvalid  out  1; s00_axi_bready  in  1.
REQ-010 s00_axi_araddr  in  4  read address; s00_axi_arprot  in  3  ignored; s00_axi_arvalid  in  1; s00_axi_arready  out  1.
REQ-011 s00_axi_rdata  out  32; s00_axi_rresp  out  2; s00_axi_rvalid  out  1; s00_axi_rready  in  1.
REQ-012 slv_reg0..slv_reg3  out  32 each  current register contents to fabric logic.
REQ-013 reg_wr_pulse  out  4  one-cycle strobe, bit n high the cycle after register n is written.

Function
REQ-014 Register select SHALL be addr[3:2]; addr[1:0] ignored; all four registers read/write.
REQ-015 AW and W SHALL be accepted independently, in either order or the same cycle; each handshake captures into its own one-entry holding buffer.
REQ-016 awready SHALL be high iff the AW buffer is empty and bvalid is low; wready likewise for the W buffer.
REQ-017 Commit SHALL occur in the cycle both buffers are full (or being filled that cycle): bytes with wstrb[k]=1 updated, others retained; both buffers cleared.
REQ-018 slv_regN and reg_wr_pulse[N] SHALL reflect the commit one cycle after it; bvalid SHALL rise in that same cycle.
REQ-019 bvalid SHALL hold with bresp=2'b00 until bready high; clears on the handshake edge; no second commit while bvalid high.
REQ-020 arready SHALL be high iff rvalid low; on AR handshake rdata registered from the addressed register, rvalid high next cycle.
REQ-021 rdata/rresp SHALL remain stable while rvalid high and rready low; rresp always 2'b00.
REQ-022 Read and commit to the same register in the same cycle: read SHALL return the pre-write value.
REQ-023 wstrb=4'b0000 SHALL complete with OKAY, leave data unchanged, and still pulse reg_wr_pulse.
REQ-024 Back-to-back: with bready/rready held high, one write per 2 cycles and one read per 2 cycles SHALL be sustained.
REQ-025 Outputs not covered above SHALL be registered; no combinational path from any valid/ready input to any ready output.

Reset
REQ-026 While s00_axi_aresetn low: awready, wready, arready, bvalid, rvalid, reg_wr_pulse = 0; bresp, rresp, rdata = 0; slv_reg0..3 = 32'h0; holding buffers empty.
REQ-027 Reset asserted mid-transaction SHALL discard pending AW/W/response state; first handshake after release is treated as new.
REQ-028 Ready outputs SHALL rise no earlier than the first clock edge after reset release.

Verification
REQ-029 Write 32'h1,2,3,4 to 0x0,0x4,0x8,0xC (wstrb 4'hF), then read each -> rdata 1,2,3,4, all resp OKAY, slv_reg0..3 match.
REQ-030 W presented 3 cycles before AW, data 32'hDEADBEEF to 0x8 -> wready handshake first, single bvalid after AW, slv_reg2=32'hDEADBEEF.
REQ-031 slv_reg1=32'h11223344, write 32'hAABBCCDD wstrb 4'b0101 -> slv_reg1=32'h11BB33DD, reg_wr_pulse=4'b0010 for one cycle.
REQ-032 bready low 10 cycles after write -> bvalid held, awready/wready low, second write stalls then completes after bready.
REQ-033 Read of 0x4 in commit cycle of write 32'h55 to 0x4 (old 32'h7) -> rdata 32'h7; next read -> 32'h55.
REQ-034 aresetn pulsed low with AW accepted, W pending, slv_reg0=32'h9 -> all outputs zero, no bvalid after release, slv_reg0=0.

Source files
------------

// File: rtl/amdc_amds_s00_axi_regs.sv
// rtl/amdc_amds_s00_axi_regs.sv - AXI4-Lite slave exposing four 32-bit registers with write strobes
module amdc_amds_s00_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg3,
  output logic [3:0]                        reg_wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;

  // One-entry holding buffers for the write address and write data channels
  logic          aw_full_q, aw_full_d;
  logic [1:0]    aw_sel_q, aw_sel_d;
  logic          w_full_q, w_full_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [SW-1:0] w_strb_q, w_strb_d;

  // Response, read and register state
  logic          bvalid_q, bvalid_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          arready_q, arready_d;
  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] regs_d [4];
  logic [3:0]    wr_pulse_q, wr_pulse_d;

  // Commit-path helpers: a buffered beat wins, otherwise the beat arriving this cycle is used
  logic          aw_hs, w_hs, ar_hs, commit;
  logic [1:0]    cm_sel;
  logic [DW-1:0] cm_data;
  logic [SW-1:0] cm_strb;

  // Handshakes are qualified by the registered readies, so no input reaches a ready output
  always_comb begin
    aw_hs   = s00_axi_awvalid & awready_q;
    w_hs    = s00_axi_wvalid & wready_q;
    ar_hs   = s00_axi_arvalid & arready_q;
    cm_sel  = aw_full_q ? aw_sel_q : s00_axi_awaddr[3:2];
    cm_data = w_full_q ? w_data_q : s00_axi_wdata;
    cm_strb = w_full_q ? w_strb_q : s00_axi_wstrb;
    commit  = (aw_full_q | aw_hs) & (w_full_q | w_hs);
  end

  // Next-state: capture beats, merge bytes on commit, track response and read data
  always_comb begin
    aw_full_d  = aw_full_q;
    aw_sel_d   = aw_sel_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_sel_d  = s00_axi_awaddr[3:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s00_axi_wdata;
      w_strb_d = s00_axi_wstrb;
    end

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      for (int k = 0; k < SW; k++) begin
        if (cm_strb[k]) begin
          regs_d[cm_sel][8*k +: 8] = cm_data[8*k +: 8];
        end
      end
      wr_pulse_d[cm_sel] = 1'b1;
    end

    bvalid_d = commit | (bvalid_q & ~s00_axi_bready);
    rvalid_d = ar_hs | (rvalid_q & ~s00_axi_rready);
    // Reads sample the register before any same-cycle commit lands
    rdata_d  = ar_hs ? regs_q[s00_axi_araddr[3:2]] : rdata_q;

    awready_d = ~aw_full_d & ~bvalid_d;
    wready_d  = ~w_full_d & ~bvalid_d;
    arready_d = ~rvalid_d;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_full_q  <= 1'b0;
      aw_sel_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      wr_pulse_q <= '0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      aw_full_q  <= aw_full_d;
      aw_sel_q   <= aw_sel_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      arready_q  <= arready_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rresp   = 2'b00;
  assign s00_axi_rdata   = rdata_q;
  assign slv_reg0        = regs_q[0];
  assign slv_reg1        = regs_q[1];
  assign slv_reg2        = regs_q[2];
  assign slv_reg3        = regs_q[3];
  assign reg_wr_pulse    = wr_pulse_q;

  // Protection bits and byte-offset address bits carry no meaning for this register file
  logic unused_ok;
  assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

endmodule
